// File: rtl/gmac_pkg.sv
// gmac_pkg: shared constants and FSM encoding for the UDP/IPv4 transmit framer
package gmac_pkg;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam int          HDR_LEN        = 42;
    localparam int          MIN_PAYLOAD    = 18;
    localparam int          MAX_PAYLOAD    = 1472;
    localparam int          CSUM_WORDS     = 10;
    typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD} state_t;
endpackage

// File: rtl/ipv4_csum_acc.sv
// ipv4_csum_acc: one's-complement header checksum accumulator with clear/add/fold
module ipv4_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic        fold,
    input  logic [15:0] word,
    output logic [15:0] csum
);
    logic [16:0] acc;
    // each add folds the previous carry back in; fold is idempotent once settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (add) acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]} + {1'b0, word};
        else if (fold) acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]};
    end
    assign csum = ~acc[15:0];
endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: frames a payload stream as Ethernet/IPv4/UDP bytes for the MAC TX channel
module udp_tx_framer
    import gmac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'hC0A805050505,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80507,
    parameter logic [15:0] LOCAL_PORT = 16'h04D2,
    parameter logic [7:0]  IP_TTL     = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [47:0] remote_mac,
    input  logic [31:0] remote_ip,
    input  logic [15:0] remote_port,
    output logic        busy,
    output logic        err_len,
    output logic        err_underrun,
    input  logic [7:0]  pl_data,
    input  logic        pl_val,
    output logic        pl_rdy,
    input  logic        tx_rdy,
    output logic        val_out,
    output logic        sof_out,
    output logic        eof_out,
    output logic [7:0]  data_out
);
    state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] len_q, rport_q, ident, totlen, udplen, csum, csum_word;
    logic [47:0] rmac_q;
    logic [31:0] rip_q;
    logic legal, accept, last_pl, short_pl, und_seen;
    logic [9:0][15:0] ip_words;
    logic [41:0][7:0] hdr;

    assign legal    = (len != 16'd0) && (len <= 16'(MAX_PAYLOAD));
    assign accept   = start && (state == IDLE) && legal;
    assign totlen   = len_q + 16'd28;
    assign udplen   = len_q + 16'd8;
    assign short_pl = len_q < 16'(MIN_PAYLOAD);
    assign last_pl  = cnt == len_q - 16'd1;
    assign busy     = state != IDLE;

    assign ip_words = {16'h4500, totlen, ident, 16'h4000, IP_TTL, IP_PROTO_UDP, 16'h0000,
                       LOCAL_IP[31:16], LOCAL_IP[15:0], rip_q[31:16], rip_q[15:0]};
    assign csum_word = ip_words[4'd9 - cnt[3:0]];

    // element 41 is the first byte on the wire
    assign hdr = {rmac_q, LOCAL_MAC, ETHERTYPE_IPV4, 8'h45, 8'h00, totlen, ident, 16'h4000,
                  IP_TTL, IP_PROTO_UDP, csum, LOCAL_IP, rip_q, LOCAL_PORT, rport_q, udplen, 16'h0000};

    ipv4_csum_acc u_csum (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .add  (state == CSUM),
        .fold (state == HDR),
        .word (csum_word),
        .csum (csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        val_out   = 1'b0;
        sof_out   = 1'b0;
        eof_out   = 1'b0;
        data_out  = 8'h00;
        pl_rdy    = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                state_nxt = CSUM;
                cnt_nxt   = '0;
            end
            CSUM: begin
                cnt_nxt = cnt + 16'd1;
                if (cnt == 16'(CSUM_WORDS - 1)) begin
                    state_nxt = HDR;
                    cnt_nxt   = '0;
                end
            end
            HDR: begin
                val_out  = 1'b1;
                sof_out  = cnt == 16'd0;
                data_out = hdr[6'd41 - cnt[5:0]];
                if (tx_rdy) begin
                    cnt_nxt = cnt + 16'd1;
                    if (cnt == 16'(HDR_LEN - 1)) begin
                        state_nxt = PAYLOAD;
                        cnt_nxt   = '0;
                    end
                end
            end
            PAYLOAD: begin
                val_out  = pl_val;
                data_out = pl_data;
                pl_rdy   = tx_rdy;
                eof_out  = pl_val && last_pl && !short_pl;
                // cnt carries on into PAD so padding always ends at byte MIN_PAYLOAD-1
                if (pl_val && tx_rdy) begin
                    cnt_nxt = cnt + 16'd1;
                    if (last_pl) state_nxt = short_pl ? PAD : IDLE;
                end
            end
            PAD: begin
                val_out = 1'b1;
                eof_out = cnt == 16'(MIN_PAYLOAD - 1);
                if (tx_rdy) begin
                    cnt_nxt = cnt + 16'd1;
                    if (eof_out) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            rmac_q       <= '0;
            rip_q        <= '0;
            rport_q      <= '0;
            ident        <= '0;
            und_seen     <= 1'b0;
            err_len      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_len      <= start && (state == IDLE) && !legal;
            err_underrun <= (state == PAYLOAD) && !pl_val && !und_seen;
            if (accept) begin
                len_q    <= len;
                rmac_q   <= remote_mac;
                rip_q    <= remote_ip;
                rport_q  <= remote_port;
                und_seen <= 1'b0;
            end else if ((state == PAYLOAD) && !pl_val) begin
                und_seen <= 1'b1;
            end
            if (eof_out && tx_rdy) ident <= ident + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: directed/randomized frames checked against a byte-queue frame model
module tb_udp_tx_framer;
    typedef logic [7:0] bq_t[$];
    localparam logic [47:0] LMAC  = 48'hC0A805050505;
    localparam logic [31:0] LIP   = 32'hC0A80507;
    localparam logic [15:0] LPORT = 16'h04D2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pl_val = 1'b0, tx_rdy = 1'b1;
    logic [15:0] len = '0, remote_port = '0;
    logic [47:0] remote_mac = '0;
    logic [31:0] remote_ip = '0;
    logic [7:0]  pl_data = '0;
    logic        busy, err_len, err_underrun, pl_rdy, val_out, sof_out, eof_out;
    logic [7:0]  data_out;

    int checks = 0, errors = 0;
    logic [15:0] model_ident = '0;
    bq_t obs;

    udp_tx_framer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .remote_mac(remote_mac),
        .remote_ip(remote_ip), .remote_port(remote_port), .busy(busy), .err_len(err_len),
        .err_underrun(err_underrun), .pl_data(pl_data), .pl_val(pl_val), .pl_rdy(pl_rdy),
        .tx_rdy(tx_rdy), .val_out(val_out), .sof_out(sof_out), .eof_out(eof_out),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t build_frame(input int n, input logic [47:0] rmac, input logic [31:0] rip,
                                        input logic [15:0] rport, input logic [15:0] id, input bq_t pl);
        bq_t q;
        logic [335:0] h;
        int s;
        h = {rmac, LMAC, 16'h0800, 8'h45, 8'h00, 16'(n + 28), id, 16'h4000, 8'd64, 8'h11, 16'h0000,
             LIP, rip, LPORT, rport, 16'(n + 8), 16'h0000};
        for (int i = 41; i >= 0; i--) q.push_back(h[8*i +: 8]);
        s = 0;
        for (int i = 0; i < 10; i++) s += int'({q[14 + 2*i], q[15 + 2*i]});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s;
        q[24] = s[15:8];
        q[25] = s[7:0];
        for (int i = 0; i < n; i++) q.push_back(pl[i]);
        while (q.size() < 60) q.push_back(8'h00);
        return q;
    endfunction

    task automatic run_frame(input string tag, input int n, input logic [31:0] rip, input int rdy_pct,
                             input int gap_at, input int gap_n, input int rst_at, input int ign_at);
        bq_t pl, exp;
        logic [47:0] rmac;
        logic [15:0] rport;
        int k, p, cyc, first, sofs, eofs, unds, idle_mid, gap_left;
        logic done, stall, pv, ps, pe, in_gap;
        logic [7:0] pd;
        rmac  = {16'($urandom), 32'($urandom)};
        rport = 16'($urandom);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        exp = build_frame(n, rmac, rip, rport, model_ident, pl);
        obs.delete();
        k = 0; p = 0; cyc = 0; first = -1; sofs = 0; eofs = 0; unds = 0; idle_mid = 0;
        gap_left = gap_n; done = 1'b0; stall = 1'b0; pv = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0;
        @(negedge clk);
        start = 1'b1; len = 16'(n); remote_mac = rmac; remote_ip = rip; remote_port = rport;
        tx_rdy = 1'b1; pl_val = 1'b0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start     = (cyc == ign_at);
            len       = (cyc == ign_at) ? 16'd5 : 16'(n);
            remote_ip = (cyc == ign_at) ? ~rip : rip;
            tx_rdy    = ($urandom_range(99) < 32'(rdy_pct));
            in_gap    = (p == gap_at) && (gap_left > 0);
            pl_val    = (p < n) && !in_gap;
            pl_data   = (p < n) ? pl[p] : 8'h00;
            #1;
            if (cyc == 1) chk({tag, "_busy_after_start"}, 64'(busy), 64'(1));
            if (stall) chk({tag, "_hold"}, 64'({val_out, sof_out, eof_out, data_out}), 64'({pv, ps, pe, pd}));
            if (val_out && first < 0) first = cyc;
            if (first >= 0 && !val_out) idle_mid++;
            if (err_underrun) unds++;
            if (val_out && rst_at >= 0 && k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_reset_outputs"},
                    64'({busy, val_out, sof_out, eof_out, pl_rdy, err_len, err_underrun, data_out}), 64'(0));
                model_ident = '0;
                done = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
            end else if (val_out && tx_rdy) begin
                chk({tag, "_data"}, 64'(data_out), 64'(exp[k]));
                chk({tag, "_sof"}, 64'(sof_out), 64'(k == 0));
                chk({tag, "_eof"}, 64'(eof_out), 64'(k == exp.size() - 1));
                obs.push_back(data_out);
                sofs += int'(sof_out);
                eofs += int'(eof_out);
                k++;
                done = eof_out;
            end
            if (pl_val && pl_rdy) p++;
            if (in_gap) gap_left--;
            stall = val_out && !tx_rdy;
            pv = val_out; pd = data_out; ps = sof_out; pe = eof_out;
        end
        if (rst_at < 0) begin
            chk({tag, "_done"}, 64'(done), 64'(1));
            chk({tag, "_bytes"}, 64'(k), 64'(exp.size()));
            chk({tag, "_sof_count"}, 64'(sofs), 64'(1));
            chk({tag, "_eof_count"}, 64'(eofs), 64'(1));
            chk({tag, "_latency"}, 64'(first), 64'(11));
            chk({tag, "_underrun_pulses"}, 64'(unds), 64'(gap_n > 0));
            if (rdy_pct == 100) chk({tag, "_gap_cycles"}, 64'(idle_mid), 64'(gap_n));
            @(negedge clk);
            start = 1'b0; pl_val = 1'b0; tx_rdy = 1'b1;
            #1;
            chk({tag, "_idle_after"}, 64'({busy, val_out}), 64'(0));
            model_ident = model_ident + 16'd1;
        end
        start = 1'b0;
        pl_val = 1'b0;
    endtask

    task automatic bad_len(input string tag, input logic [15:0] v);
        int act;
        @(negedge clk);
        start = 1'b1; len = v;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_err_len"}, 64'(err_len), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        act = 0;
        repeat (14) begin
            @(negedge clk);
            #1;
            act += int'(err_len) + int'(busy) + int'(val_out);
        end
        chk({tag, "_quiet"}, 64'(act), 64'(0));
    endtask

    initial begin
        #1;
        chk("reset_outputs", 64'({busy, val_out, sof_out, eof_out, pl_rdy, err_len, err_underrun, data_out}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame("t1", 4, 32'hC0A80501, 100, -1, 0, -1, -1);
        chk("t1_size", 64'(obs.size()), 64'(60));
        chk("t1_totlen", 64'({obs[16], obs[17]}), 64'(16'h0020));
        chk("t1_csum", 64'({obs[24], obs[25]}), 64'(16'hAF74));
        chk("t1_udplen", 64'({obs[38], obs[39]}), 64'(16'h000C));

        run_frame("t2", 1472, 32'($urandom), 60, -1, 0, -1, -1);
        chk("t2_size", 64'(obs.size()), 64'(1514));
        chk("t2_totlen", 64'({obs[16], obs[17]}), 64'(16'h05DC));

        bad_len("t3_zero", 16'd0);
        bad_len("t3_big", 16'd1473);

        force dut.ident = 16'hFFFF;
        model_ident = 16'hFFFF;
        @(negedge clk);
        release dut.ident;
        run_frame("t4a", 20, 32'($urandom), 100, -1, 0, -1, 30);
        chk("t4a_ident", 64'({obs[18], obs[19]}), 64'(16'hFFFF));
        run_frame("t4b", 17, 32'($urandom), 80, -1, 0, -1, -1);
        chk("t4b_ident", 64'({obs[18], obs[19]}), 64'(16'h0000));

        run_frame("t5", 40, 32'($urandom), 100, 10, 3, -1, -1);
        chk("t5_size", 64'(obs.size()), 64'(82));

        run_frame("t6_abort", 30, 32'($urandom), 100, -1, 0, 20, -1);
        run_frame("t6_clean", 25, 32'($urandom), 70, -1, 0, -1, -1);
        chk("t6_ident", 64'({obs[18], obs[19]}), 64'(16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
